// File: rtl/div_pkg.sv
// Shared types and constants for the divider front-end sequencer.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_IDIV = 2'd1,
    DIV_OP_AAM  = 2'd2,
    DIV_OP_RSVD = 2'd3
  } DivOp_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_START = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_RESP  = 2'd3
  } DivSeqState_t;

  localparam logic [7:0] DIV_EXCEPTION_VECTOR = 8'd0;

endpackage

// File: rtl/div_sequencer.sv
// Owns the shared divider: latches DIV/IDIV/AAM operands, pulses start, watches
// for completion with a watchdog and returns the result over valid/ready.
module div_sequencer
  import div_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned TIMER_W        = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_is_8_bit,
  input  logic [31:0] req_dividend,
  input  logic [15:0] req_divisor,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_quotient,
  output logic [15:0] rsp_remainder,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        div_start,
  output logic        div_is_8_bit,
  output logic        div_is_signed,
  output logic [31:0] div_dividend,
  output logic [15:0] div_divisor,
  input  logic        div_busy,
  input  logic        div_complete,
  input  logic        div_error,
  input  logic [15:0] div_quotient,
  input  logic [15:0] div_remainder
);

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  DivSeqState_t       state_q, state_d;
  DivOp_t             req_op_s;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_error_q, rsp_error_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic [15:0]        rsp_quotient_q, rsp_quotient_d;
  logic [15:0]        rsp_remainder_q, rsp_remainder_d;
  logic               div_start_q, div_start_d;
  logic               div_is_8_bit_q, div_is_8_bit_d;
  logic               div_is_signed_q, div_is_signed_d;
  logic [31:0]        div_dividend_q, div_dividend_d;
  logic [15:0]        div_divisor_q, div_divisor_d;
  logic               drop_q, drop_d;
  logic               is_aam_q, is_aam_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               unused_s;

  assign req_op_s = DivOp_t'(req_op);
  // Busy is observed only; the watchdog alone bounds the wait.
  assign unused_s = div_busy ^ (|DIV_EXCEPTION_VECTOR);

  // Next-state, operand capture, watchdog and response latching.
  always_comb begin
    state_d         = state_q;
    drop_d          = drop_q;
    is_aam_d        = is_aam_q;
    timer_d         = timer_q;
    rsp_error_d     = rsp_error_q;
    rsp_timeout_d   = rsp_timeout_q;
    rsp_quotient_d  = rsp_quotient_q;
    rsp_remainder_d = rsp_remainder_q;
    div_is_8_bit_d  = div_is_8_bit_q;
    div_is_signed_d = div_is_signed_q;
    div_dividend_d  = div_dividend_q;
    div_divisor_d   = div_divisor_q;
    case (state_q)
      SEQ_IDLE: begin
        if (req_valid && !flush) begin
          div_is_8_bit_d  = req_is_8_bit;
          div_is_signed_d = 1'b0;
          div_dividend_d  = req_dividend;
          div_divisor_d   = req_divisor;
          is_aam_d        = 1'b0;
          drop_d          = 1'b0;
          rsp_error_d     = 1'b0;
          rsp_timeout_d   = 1'b0;
          rsp_quotient_d  = 16'h0000;
          rsp_remainder_d = 16'h0000;
          state_d         = SEQ_START;
          case (req_op_s)
            DIV_OP_DIV:  div_is_signed_d = 1'b0;
            DIV_OP_IDIV: div_is_signed_d = 1'b1;
            DIV_OP_AAM: begin
              div_is_8_bit_d = 1'b1;
              div_dividend_d = {24'h000000, req_dividend[7:0]};
              is_aam_d       = 1'b1;
            end
            DIV_OP_RSVD: begin
              rsp_error_d = 1'b1;
              state_d     = SEQ_RESP;
            end
            default: state_d = SEQ_IDLE;
          endcase
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_START: begin
        timer_d = TIMER_W'(0);
        drop_d  = drop_q | flush;
        state_d = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        timer_d = timer_q + TIMER_W'(1);
        drop_d  = drop_q | flush;
        if (div_complete) begin
          rsp_error_d     = div_error;
          rsp_timeout_d   = 1'b0;
          rsp_quotient_d  = is_aam_q ? {8'h00, div_quotient[7:0]}  : div_quotient;
          rsp_remainder_d = is_aam_q ? {8'h00, div_remainder[7:0]} : div_remainder;
          drop_d          = 1'b0;
          state_d         = (drop_q || flush) ? SEQ_IDLE : SEQ_RESP;
        end else if (timer_q == TIMEOUT_LAST) begin
          rsp_error_d     = 1'b1;
          rsp_timeout_d   = 1'b1;
          rsp_quotient_d  = 16'h0000;
          rsp_remainder_d = 16'h0000;
          drop_d          = 1'b0;
          state_d         = (drop_q || flush) ? SEQ_IDLE : SEQ_RESP;
        end else begin
          state_d = SEQ_WAIT;
        end
      end
      SEQ_RESP: begin
        if (flush || rsp_ready) begin
          state_d = SEQ_IDLE;
        end else begin
          state_d = SEQ_RESP;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
    // Handshake outputs are registered images of the upcoming state.
    req_ready_d = (state_d == SEQ_IDLE);
    rsp_valid_d = (state_d == SEQ_RESP);
    div_start_d = (state_d == SEQ_START);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= SEQ_IDLE;
      req_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_error_q     <= 1'b0;
      rsp_timeout_q   <= 1'b0;
      rsp_quotient_q  <= 16'h0000;
      rsp_remainder_q <= 16'h0000;
      div_start_q     <= 1'b0;
      div_is_8_bit_q  <= 1'b0;
      div_is_signed_q <= 1'b0;
      div_dividend_q  <= 32'h00000000;
      div_divisor_q   <= 16'h0000;
      drop_q          <= 1'b0;
      is_aam_q        <= 1'b0;
      timer_q         <= TIMER_W'(0);
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_error_q     <= rsp_error_d;
      rsp_timeout_q   <= rsp_timeout_d;
      rsp_quotient_q  <= rsp_quotient_d;
      rsp_remainder_q <= rsp_remainder_d;
      div_start_q     <= div_start_d;
      div_is_8_bit_q  <= div_is_8_bit_d;
      div_is_signed_q <= div_is_signed_d;
      div_dividend_q  <= div_dividend_d;
      div_divisor_q   <= div_divisor_d;
      drop_q          <= drop_d;
      is_aam_q        <= is_aam_d;
      timer_q         <= timer_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_error     = rsp_error_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign rsp_quotient  = rsp_quotient_q;
  assign rsp_remainder = rsp_remainder_q;
  assign div_start     = div_start_q;
  assign div_is_8_bit  = div_is_8_bit_q;
  assign div_is_signed = div_is_signed_q;
  assign div_dividend  = div_dividend_q;
  assign div_divisor   = div_divisor_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: behavioural divider, vector table, random ops vs. arithmetic model.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic        req_is_8_bit = 1'b0;
  logic [31:0] req_dividend = 32'h0;
  logic [15:0] req_divisor = 16'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_quotient;
  logic [15:0] rsp_remainder;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        div_start;
  logic        div_is_8_bit;
  logic        div_is_signed;
  logic [31:0] div_dividend;
  logic [15:0] div_divisor;
  logic        div_busy;
  logic        div_complete = 1'b0;
  logic        div_error = 1'b0;
  logic [15:0] div_quotient = 16'h0;
  logic [15:0] div_remainder = 16'h0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  div_sequencer #(.TIMEOUT_CYCLES(40), .TIMER_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_is_8_bit(req_is_8_bit), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .div_start(div_start), .div_is_8_bit(div_is_8_bit), .div_is_signed(div_is_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_busy(div_busy),
    .div_complete(div_complete), .div_error(div_error), .div_quotient(div_quotient),
    .div_remainder(div_remainder)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // x86 divide semantics on plain integers: returns {error, quotient16, remainder16}.
  function automatic logic [32:0] arith(input logic sgn, input logic is8,
                                        input logic [31:0] a, input logic [15:0] d);
    longint na, nd, q, r, lo, hi;
    logic [32:0] res;
    if (is8) begin
      if (sgn) begin
        na = longint'($signed(a[15:0])); nd = longint'($signed(d[7:0]));
        lo = longint'(-128); hi = longint'(127);
      end else begin
        na = longint'(a[15:0]); nd = longint'(d[7:0]);
        lo = longint'(0); hi = longint'(255);
      end
    end else begin
      if (sgn) begin
        na = longint'($signed(a)); nd = longint'($signed(d));
        lo = longint'(-32768); hi = longint'(32767);
      end else begin
        na = longint'(a); nd = longint'(d);
        lo = longint'(0); hi = longint'(65535);
      end
    end
    res = {1'b1, 32'h0};
    if (nd != longint'(0)) begin
      q = na / nd;
      r = na % nd;
      if (q >= lo && q <= hi) res = {1'b0, q[15:0], r[15:0]};
    end
    return res;
  endfunction

  // Expected response {timeout, error, quotient, remainder} from the request alone.
  function automatic logic [33:0] ref_rsp(input logic [1:0] op, input logic is8,
                                          input logic [31:0] a, input logic [15:0] d);
    logic [32:0] x;
    case (op)
      2'd0: x = arith(1'b0, is8, a, d);
      2'd1: x = arith(1'b1, is8, a, d);
      2'd2: begin
        x = arith(1'b0, 1'b1, {24'h0, a[7:0]}, d);
        x = {x[32], 8'h00, x[23:16], 8'h00, x[7:0]};
      end
      default: x = {1'b1, 32'h0};
    endcase
    return {1'b0, x};
  endfunction

  // Behavioural divider: completes div_lat+1 cycles after seeing start, unless hung.
  int div_lat = 0;
  bit div_hang = 1'b0;
  logic pend = 1'b0;
  int cnt = 0;
  assign div_busy = pend;
  always @(posedge clk) begin
    div_complete <= 1'b0;
    if (!reset_n) begin
      pend <= 1'b0;
    end else if (div_start) begin
      pend <= !div_hang;
      cnt  <= div_lat;
    end else if (pend) begin
      if (cnt == 0) begin
        pend <= 1'b0;
        div_complete <= 1'b1;
        {div_error, div_quotient, div_remainder} <=
          arith(div_is_signed, div_is_8_bit, div_dividend, div_divisor);
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic is8,
                       input logic [31:0] a, input logic [15:0] d);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_is_8_bit = is8; req_dividend = a; req_divisor = d;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // One full operation; cycle k=0 is the first cycle after acceptance.
  task automatic run_op(input string tag, input logic [1:0] op, input logic is8,
                        input logic [31:0] a, input logic [15:0] d, input int hold,
                        output int lat_k, output int starts,
                        output logic [15:0] q, output logic [15:0] r,
                        output logic err, output logic to,
                        output logic [31:0] o_a, output logic [15:0] o_d,
                        output logic o_8, output logic o_s);
    bit got;
    issue(op, is8, a, d);
    starts = 0; got = 1'b0; lat_k = -1;
    q = 16'h0; r = 16'h0; err = 1'b0; to = 1'b0;
    o_a = 32'h0; o_d = 16'h0; o_8 = 1'b0; o_s = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (div_start) begin
        starts++;
        o_a = div_dividend; o_d = div_divisor; o_8 = div_is_8_bit; o_s = div_is_signed;
      end
      if (rsp_valid) begin
        got = 1'b1; lat_k = k;
        q = rsp_quotient; r = rsp_remainder; err = rsp_error; to = rsp_timeout;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check({tag, " rsp_valid seen"}, 64'd0, 64'd1);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, " held"}, {29'h0, rsp_valid, rsp_error, rsp_timeout, rsp_quotient, rsp_remainder},
              {29'h0, 1'b1, err, to, q, r});
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, " after handshake"}, {62'h0, rsp_valid, req_ready}, {62'h0, 1'b0, 1'b1});
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        is8;
    logic [31:0] a;
    logic [15:0] d;
    int          lat;
    logic [15:0] q;
    logic [15:0] r;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat_k, starts, seen_rsp, kc;
    logic [15:0] q, r, o_d;
    logic [31:0] o_a;
    logic err, to, o_8, o_s;
    logic [33:0] exp_rsp;
    logic [1:0] rop;
    logic ris8;
    logic [31:0] ra;
    logic [15:0] rd;
    int rlat;

    // op: 0=DIV 1=IDIV 2=AAM 3=reserved
    vecs[0] = '{2'd0, 1'b0, 32'h00010000, 16'h0002, 2, 16'h8000, 16'h0000, 1'b0};
    vecs[1] = '{2'd1, 1'b1, 32'h0000FFF9, 16'h0002, 1, 16'hFFFD, 16'hFFFF, 1'b0};
    vecs[2] = '{2'd2, 1'b0, 32'h0000002F, 16'h000A, 0, 16'h0004, 16'h0007, 1'b0};
    vecs[3] = '{2'd0, 1'b0, 32'h00001234, 16'h0000, 0, 16'h0000, 16'h0000, 1'b1};
    vecs[4] = '{2'd0, 1'b1, 32'h00000100, 16'h0001, 3, 16'h0000, 16'h0000, 1'b1};
    vecs[5] = '{2'd1, 1'b0, 32'hFFFF8000, 16'hFFFF, 2, 16'h0000, 16'h0000, 1'b1};
    vecs[6] = '{2'd1, 1'b0, 32'hFFFFFF85, 16'h000A, 4, 16'hFFF4, 16'hFFFD, 1'b0};
    vecs[7] = '{2'd3, 1'b0, 32'h12345678, 16'h0003, 0, 16'h0000, 16'h0000, 1'b1};
    vecs[8] = '{2'd2, 1'b1, 32'hABCD12FF, 16'h1234, 1, 16'h0004, 16'h002F, 1'b0};
    vecs[9] = '{2'd0, 1'b1, 32'h12345678, 16'hFFC8, 5, 16'h006E, 16'h0088, 1'b0};

    repeat (2) @(negedge clk);
    check("reset outputs",
          {29'h0, req_ready, rsp_valid, rsp_error, rsp_timeout, div_start, div_is_8_bit, div_is_signed,
           rsp_quotient, rsp_remainder},
          {29'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0});
    check("reset operands", {div_divisor, div_dividend}, 64'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      div_lat = vecs[i].lat; div_hang = 1'b0;
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].is8, vecs[i].a, vecs[i].d, i % 3,
             lat_k, starts, q, r, err, to, o_a, o_d, o_8, o_s);
      check($sformatf("vec%0d result", i), {31'h0, err, q, r}, {31'h0, vecs[i].err, vecs[i].q, vecs[i].r});
      check($sformatf("vec%0d timeout", i), {63'h0, to}, 64'h0);
      check($sformatf("vec%0d starts", i), 64'(starts), (vecs[i].op == 2'd3) ? 64'd0 : 64'd1);
      check($sformatf("vec%0d latency", i), 64'(lat_k),
            (vecs[i].op == 2'd3) ? 64'd0 : 64'(vecs[i].lat + 3));
      if (vecs[i].op != 2'd3)
        check($sformatf("vec%0d operands", i), {14'h0, o_8, o_s, o_d, o_a},
              {14'h0, (vecs[i].op == 2'd2) ? 1'b1 : vecs[i].is8, vecs[i].op == 2'd1, vecs[i].d,
               (vecs[i].op == 2'd2) ? {24'h0, vecs[i].a[7:0]} : vecs[i].a});
    end

    // Divider never completes: watchdog error after 40 WAIT cycles, response held.
    div_hang = 1'b1;
    run_op("watchdog", 2'd0, 1'b0, 32'h00000064, 16'h0005, 5,
           lat_k, starts, q, r, err, to, o_a, o_d, o_8, o_s);
    check("watchdog result", {30'h0, to, err, q, r}, {30'h0, 1'b1, 1'b1, 32'h0});
    check("watchdog latency", 64'(lat_k), 64'd41);
    check("watchdog starts", 64'(starts), 64'd1);
    div_hang = 1'b0;

    // Flush in IDLE: request not accepted.
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_op = 2'd0; req_dividend = 32'h10; req_divisor = 16'h2;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush idle", {62'h0, div_start, req_ready}, {62'h0, 1'b0, 1'b1});

    // Flush three cycles into WAIT: no response, ready the cycle after completion.
    div_lat = 10;
    issue(2'd0, 1'b0, 32'h00000100, 16'h0004);
    seen_rsp = 0; kc = -1;
    for (int k = 0; k < 60; k++) begin
      flush = (k == 3);
      if (rsp_valid) seen_rsp++;
      if (div_complete && kc < 0) begin
        kc = k;
        check("flush ready at complete", {63'h0, req_ready}, 64'd0);
      end else if (kc >= 0 && k == kc + 1) begin
        check("flush ready after complete", {63'h0, req_ready}, 64'd1);
      end
      if (kc >= 0 && k > kc + 3) break;
      @(negedge clk);
    end
    flush = 1'b0;
    check("flush complete seen", 64'(kc >= 0), 64'd1);
    check("flush no response", 64'(seen_rsp), 64'd0);

    // Flush in RESP: response withdrawn next cycle.
    div_lat = 0;
    issue(2'd0, 1'b0, 32'h00000009, 16'h0003);
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    check("resp before flush", {63'h0, rsp_valid}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush resp", {62'h0, rsp_valid, req_ready}, {62'h0, 1'b0, 1'b1});

    // Asynchronous reset in the middle of WAIT.
    div_hang = 1'b1;
    issue(2'd1, 1'b0, 32'h00005555, 16'h0011);
    repeat (5) @(negedge clk);
    check("pre-reset busy", {63'h0, req_ready}, 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async reset", {30'h0, req_ready, rsp_valid, div_start, div_is_signed, div_dividend},
          {30'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    reset_n = 1'b1;
    div_hang = 1'b0;

    // Random operations against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      rop  = 2'($urandom_range(0, 3));
      ris8 = 1'($urandom_range(0, 1));
      ra   = $urandom;
      if ($urandom_range(0, 1) == 1) ra = ra & 32'h0000_0FFF;
      rd   = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rd = 16'h0;
      rlat = $urandom_range(0, 6);
      div_lat = rlat;
      exp_rsp = ref_rsp(rop, ris8, ra, rd);
      run_op($sformatf("rnd%0d", i), rop, ris8, ra, rd, $urandom_range(0, 2),
             lat_k, starts, q, r, err, to, o_a, o_d, o_8, o_s);
      check($sformatf("rnd%0d op%0d a=%h d=%h", i, rop, ra, rd), {30'h0, to, err, q, r}, {30'h0, exp_rsp});
      check($sformatf("rnd%0d latency", i), 64'(lat_k), (rop == 2'd3) ? 64'd0 : 64'(rlat + 3));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
